parallel_to_serial: RTL and testbench

Downstream consumer of the divided-clock stage. Takes parallel words at word rate and shifts them out one bit per `clk` cycle, MSB first, so one word occupies WIDTH `clk` cycles.
After reset it emits a fixed preamble of SYNC_WORDS idle/comma words, then serializes upstream data. The idle word is inserted whenever upstream has nothing valid at a word boundary.
Its output feeds the serial link model and the serial-to-parallel receiver.

---
 rtl/parallel_to_serial_pkg.sv | 22 ++
 rtl/parallel_to_serial_word_shifter.sv | 51 +++++
 rtl/parallel_to_serial.sv | 100 ++++++++++
 tb/tb_parallel_to_serial.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/parallel_to_serial_pkg.sv
// Shared definitions for the serializer: state encoding, default sizes and the comma word
// that the receiver also uses for alignment.
package parallel_to_serial_pkg;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam int unsigned DEF_SYNC_WORDS = 4;

    // K28.5 comma: preamble filler and idle fill when upstream has nothing valid
    localparam logic [7:0] COM_WORD = 8'hBC;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2
    } p2s_state_e;

    // Counter width able to hold values 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/parallel_to_serial_word_shifter.sv
// Loadable MSB-first shift register with a bit counter; flags the word boundary
// (last bit of the current word on the output).
module word_shifter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enb,
    input  logic [WIDTH-1:0] load_word,
    output logic             msb,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             boundary_c
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign boundary_c = (cnt_q == LAST_BIT);
    assign msb        = shift_q[WIDTH-1];
    assign bit_cnt    = cnt_q;

    // Load on a boundary, otherwise shift left one place; everything holds while disabled
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (enb) begin
            if (boundary_c) begin
                shift_d = load_word;
                cnt_d   = '0;
            end else begin
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter resets to the last bit so the first enabled edge is a boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= LAST_BIT;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/parallel_to_serial.sv
// Word-to-bit serializer: sends a comma preamble after reset, then upstream words MSB first,
// filling with the comma word whenever upstream has nothing valid at a word boundary.
module parallel_to_serial
    import parallel_to_serial_pkg::*;
#(
    parameter int unsigned      WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] IDLE_WORD  = WIDTH'(COM_WORD),
    parameter int unsigned      SYNC_WORDS = DEF_SYNC_WORDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             validIn,
    output logic             ready,
    output logic             dataOut,
    output logic             validOut,
    output logic             wordStart
);

    localparam int unsigned      CNT_W     = cnt_bits(WIDTH);
    localparam int unsigned      SC_W      = cnt_bits(SYNC_WORDS + 1);
    localparam logic [SC_W-1:0]  SYNC_LAST = SC_W'(SYNC_WORDS - 1);

    p2s_state_e       state_q, state_d;
    logic [SC_W-1:0]  sync_cnt_q, sync_cnt_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] load_word;
    logic             msb;
    logic [CNT_W-1:0] bit_cnt;
    logic             boundary_c;
    logic             load_edge;

    word_shifter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_word_shifter (
        .clk        (clk),
        .rst_n      (rst),
        .enb        (enb),
        .load_word  (load_word),
        .msb        (msb),
        .bit_cnt    (bit_cnt),
        .boundary_c (boundary_c)
    );

    assign load_edge = enb & boundary_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // State only moves on enabled word boundaries
    always_comb begin
        state_d = state_q;
        if (load_edge) begin
            case (state_q)
                ST_IDLE:   state_d = (SYNC_WORDS <= 1) ? ST_ACTIVE : ST_SYNC;
                ST_SYNC:   if (sync_cnt_q == SYNC_LAST) state_d = ST_ACTIVE;
                ST_ACTIVE: state_d = ST_ACTIVE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Load mux, preamble counter, live flag and the interface strobes
    always_comb begin
        load_word  = IDLE_WORD;
        sync_cnt_d = sync_cnt_q;
        valid_d    = valid_q;
        if (load_edge) begin
            valid_d = 1'b1;
            case (state_q)
                ST_IDLE:   sync_cnt_d = SC_W'(1);
                ST_SYNC:   sync_cnt_d = sync_cnt_q + SC_W'(1);
                ST_ACTIVE: if (validIn) load_word = dataIn;
                default:   sync_cnt_d = sync_cnt_q;
            endcase
        end
        ready     = load_edge & (state_q == ST_ACTIVE);
        dataOut   = msb;
        validOut  = valid_q & enb;
        wordStart = valid_q & enb & (bit_cnt == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_cnt_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            sync_cnt_q <= sync_cnt_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Self-checking bench for parallel_to_serial: word-level reference model compared every cycle,
// plus directed scenarios with literal expected bit streams.
module tb_parallel_to_serial;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned SYNC_WORDS = 4;
    localparam logic [7:0]  IDLE       = 8'hBC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enb = 1'b0;
    logic       validIn = 1'b0;
    logic [7:0] dataIn = 8'h00;
    logic       ready, dataOut, validOut, wordStart;

    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;
    logic [31:0] acc;

    parallel_to_serial #(
        .WIDTH      (WIDTH),
        .IDLE_WORD  (IDLE),
        .SYNC_WORDS (SYNC_WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .dataIn    (dataIn),
        .validIn   (validIn),
        .ready     (ready),
        .dataOut   (dataOut),
        .validOut  (validOut),
        .wordStart (wordStart)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: current word on the wire, bit position within it, words sent so far
    logic [7:0] m_word  = 8'h00;
    int         m_pos   = WIDTH - 1;
    int         m_words = 0;
    bit         m_live  = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_word  = 8'h00;
            m_pos   = WIDTH - 1;
            m_words = 0;
            m_live  = 1'b0;
        end else if (enb) begin
            if (m_pos == WIDTH - 1) begin
                if (m_words < SYNC_WORDS) m_word = IDLE;
                else                      m_word = validIn ? dataIn : IDLE;
                m_words++;
                m_pos  = 0;
                m_live = 1'b1;
            end else begin
                m_pos++;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic exp_valid;
            exp_valid = rst && enb && m_live;
            chk("model_dataOut", 32'(dataOut), 32'(m_word[WIDTH-1-m_pos]));
            chk("model_ready", 32'(ready),
                32'(rst && enb && (m_words >= SYNC_WORDS) && (m_pos == WIDTH - 1)));
            chk("model_validOut", 32'(validOut), 32'(exp_valid));
            chk("model_wordStart", 32'(wordStart), 32'(exp_valid && (m_pos == 0)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: ready timeout, got %b expected 1", name, ready);
        end
    endtask

    // Present a word on the ready strobe; returns just after the loading edge (MSB on the wire)
    task automatic send_word(input logic [7:0] d, input logic v, input string name);
        wait_ready(name);
        dataIn  = d;
        validIn = v;
        tick();
        validIn = 1'b0;
        dataIn  = 8'h00;
    endtask

    // Shift n displayed bits into a, ending on the last one without advancing past it
    task automatic grab(input int n, inout logic [31:0] a);
        for (int i = 0; i < n; i++) begin
            a = {a[30:0], dataOut};
            if (i < n - 1) tick();
        end
    endtask

    // Caller releases reset just after a rising edge; checks the full comma preamble
    task automatic check_preamble(input string name);
        logic [31:0] a;
        a = '0;
        for (int i = 0; i < 32; i++) begin
            tick();
            a = {a[30:0], dataOut};
            chk({name, "_ready"}, 32'(ready), 32'(i == 31));
            chk({name, "_wordStart"}, 32'(wordStart), 32'(i % 8 == 0));
            if (i == 0) chk({name, "_validOut_rise"}, 32'(validOut), 32'd1);
        end
        chk({name, "_bits"}, a, 32'hBCBC_BCBC);
    endtask

    initial begin
        #1 rst = 1'b0;
        #1 cmp_en = 1'b1;
        #38;
        chk("reset_dataOut", 32'(dataOut), 32'd0);
        chk("reset_validOut", 32'(validOut), 32'd0);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_wordStart", 32'(wordStart), 32'd0);

        @(posedge clk);
        #2;
        rst = 1'b1;
        enb = 1'b1;
        check_preamble("preamble");

        acc = '0;
        send_word(8'hA5, 1'b1, "a5_word");
        grab(8, acc);
        chk("a5_bits", {24'd0, acc[7:0]}, 32'h0000_00A5);

        acc = '0;
        send_word(8'h5A, 1'b0, "idle_fill");
        grab(8, acc);
        chk("idle_fill_bits", {24'd0, acc[7:0]}, 32'h0000_00BC);

        acc = '0;
        send_word(8'h00, 1'b1, "b2b_0");
        grab(8, acc);
        send_word(8'hFF, 1'b1, "b2b_1");
        grab(8, acc);
        send_word(8'h3C, 1'b1, "b2b_2");
        grab(8, acc);
        chk("b2b_bits", {8'd0, acc[23:0]}, 32'h0000_FF3C);

        // Freeze mid-word: four bits out, then 20 disabled cycles, then the rest
        acc = '0;
        send_word(8'hA5, 1'b1, "freeze_word");
        grab(4, acc);
        enb = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("freeze_dataOut", 32'(dataOut), 32'd0);
            chk("freeze_validOut", 32'(validOut), 32'd0);
            chk("freeze_ready", 32'(ready), 32'd0);
            chk("freeze_wordStart", 32'(wordStart), 32'd0);
        end
        enb = 1'b1;
        tick();
        grab(4, acc);
        chk("freeze_bits", {24'd0, acc[7:0]}, 32'h0000_00A5);
        chk("freeze_next_ready", 32'(ready), 32'd1);

        // Asynchronous reset between edges in the middle of an all-ones word
        acc = '0;
        send_word(8'hFF, 1'b1, "areset_word");
        grab(3, acc);
        chk("areset_pre_dataOut", 32'(dataOut), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("areset_dataOut", 32'(dataOut), 32'd0);
        chk("areset_validOut", 32'(validOut), 32'd0);
        chk("areset_ready", 32'(ready), 32'd0);
        chk("areset_wordStart", 32'(wordStart), 32'd0);
        repeat (3) tick();
        rst = 1'b1;
        check_preamble("repreamble");

        acc = '0;
        send_word(8'hC3, 1'b1, "post_reset_word");
        grab(8, acc);
        chk("post_reset_bits", {24'd0, acc[7:0]}, 32'h0000_00C3);

        tick();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
